// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and requester indices for spi_arb
//
// Purpose : common definitions imported by the SPI arbiter and its users.
// Contents: arb_state_e (IDLE/XFER/GAP), REQ_INERT / REQ_A2D requester indices.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_e;

   localparam logic REQ_INERT = 1'b0;   // inertial sensor interface
   localparam logic REQ_A2D   = 1'b1;   // A2D / IR interface

endpackage

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-requester round-robin arbiter in front of one SPI_mnrch
//
// Purpose : shares one SPI master between the inertial (0) and A2D/IR (1)
//           interfaces; forces GAP_CYC idle clocks between transactions and
//           aborts a transaction via watchdog if spi_done never arrives.
// Ports   : clk, rst_n           clock, async active-low reset
//           req*/lock*/wt_data*  requester side inputs
//           gnt*/done*/err*      one-cycle pulses back to requesters
//           rd_data              broadcast read word (combinational pass-through)
//           wrt/wt_data          start pulse and command word to SPI_mnrch
//           spi_done/spi_rd_data/spi_SS_n  from SPI_mnrch
//           SS0_n/SS1_n          per-slave selects
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int GAP_CYC = 2,
   parameter int TO_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic [15:0] wt_data0,
   input  logic [15:0] wt_data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] wt_data,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data,
   input  logic        spi_SS_n,
   output logic        SS0_n,
   output logic        SS1_n
);

   arb_state_e      state_q, state_d;
   logic            owner_q, owner_d;
   logic            prio_q,  prio_d;
   logic [TO_W-1:0] wd_q,    wd_d;
   logic [3:0]      gap_q,   gap_d;

   logic win;
   logic own_lock;
   logic xfer_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= REQ_INERT;
         prio_q  <= REQ_INERT;
         wd_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         wd_q    <= wd_d;
         gap_q   <= gap_d;
      end
   end

   assign rd_data  = spi_rd_data;
   assign own_lock = (owner_q == REQ_A2D) ? lock1 : lock0;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      wd_d     = wd_q;
      gap_d    = gap_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      done0    = 1'b0;
      done1    = 1'b0;
      err0     = 1'b0;
      err1     = 1'b0;
      wrt      = 1'b0;
      wt_data  = 16'h0000;
      win      = REQ_INERT;
      xfer_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               // A lone requester wins outright; a tie goes to the pointer.
               win     = (req0 && req1) ? prio_q : req1;
               wrt     = 1'b1;
               wt_data = (win == REQ_A2D) ? wt_data1 : wt_data0;
               gnt0    = (win == REQ_INERT);
               gnt1    = (win == REQ_A2D);
               owner_d = win;
               // The wrt cycle itself is watchdog count 1.
               wd_d    = TO_W'(1);
               state_d = ST_XFER;
            end
         end

         ST_XFER: begin
            // spi_done takes precedence over a simultaneous watchdog expiry.
            if (spi_done) begin
               done0    = (owner_q == REQ_INERT);
               done1    = (owner_q == REQ_A2D);
               xfer_end = 1'b1;
            end else if (&wd_q) begin
               err0     = (owner_q == REQ_INERT);
               err1     = (owner_q == REQ_A2D);
               xfer_end = 1'b1;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end

            if (xfer_end) begin
               prio_d  = own_lock ? owner_q : ~owner_q;
               wd_d    = '0;
               gap_d   = '0;
               state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_q == 4'(GAP_CYC - 1)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Pulses must stay quiet while reset is held even if req is high.
      if (!rst_n) begin
         gnt0    = 1'b0;
         gnt1    = 1'b0;
         done0   = 1'b0;
         done1   = 1'b0;
         err0    = 1'b0;
         err1    = 1'b0;
         wrt     = 1'b0;
         wt_data = 16'h0000;
      end
   end

   assign SS0_n = (state_q == ST_XFER && owner_q == REQ_INERT) ? spi_SS_n : 1'b1;
   assign SS1_n = (state_q == ST_XFER && owner_q == REQ_A2D)   ? spi_SS_n : 1'b1;

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter GAP_CYC, default 2, meaning idle clocks forced between consecutive SPI transactions (0..15).
REQ-002 Parameter TO_W, default 16, meaning width of the transaction watchdog counter.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  transaction request; req0 = inertial interface, req1 = A2D/IR interface.
REQ-006 lock0, lock1  input  1 each  owner requests to keep priority for its next transaction.
REQ-007 wt_data0, wt_data1  input  16 each  command word of each requester.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, wt_data sampled.
REQ-009 done0, done1  output  1 each  one-cycle pulse: owner's transaction complete, rd_data valid.
REQ-010 err0, err1  output  1 each  one-cycle pulse: owner's transaction aborted by watchdog.
REQ-011 rd_data  output  16  read word from SPI_mnrch, broadcast to both requesters.
REQ-012 wrt  output  1  start pulse to SPI_mnrch.
REQ-013 wt_data  output  16  command word to SPI_mnrch.
REQ-014 spi_done  input  1  done from SPI_mnrch.
REQ-015 spi_rd_data  input  16  rd_data from SPI_mnrch.
REQ-016 spi_SS_n  input  1  SS_n from SPI_mnrch.
REQ-017 SS0_n, SS1_n  output  1 each  per-slave select: inertial sensor, A2D.

Function
REQ-018 The block SHALL implement states IDLE, XFER, GAP.
REQ-019 In IDLE with any req high, the block SHALL, same cycle, assert wrt, drive wt_data from the winner, pulse the winner's gnt, register owner, and go to XFER.
REQ-020 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; after reset requester 0 has priority.
REQ-021 The priority pointer SHALL update at transaction end to favour the non-owner, except when the owner's lock is high at that cycle, in which case the owner keeps priority.
REQ-022 In IDLE with no req, wrt, gnt, done, err SHALL be 0 and wt_data SHALL be 0x0000.
REQ-023 In XFER, spi_done high SHALL pulse the owner's done for exactly one cycle, with rd_data = spi_rd_data that cycle, and move to GAP.
REQ-024 rd_data SHALL pass spi_rd_data combinationally at all times.
REQ-025 In XFER a watchdog SHALL count clocks from the wrt cycle; reaching all-ones without spi_done SHALL pulse the owner's err, go to GAP, and not pulse done.
REQ-026 spi_done and watchdog expiry in the same cycle SHALL be treated as done (no err).
REQ-027 GAP SHALL last exactly GAP_CYC cycles; GAP_CYC = 0 SHALL return to IDLE the cycle after XFER ends.
REQ-028 Requests arriving during XFER/GAP SHALL be held by the requester (req stays high) and arbitrated in the next IDLE; no request queuing inside the block.
REQ-029 spi_done outside XFER SHALL be ignored.
REQ-030 SS0_n SHALL equal spi_SS_n when owner = 0 in XFER, else 1; SS1_n likewise for owner = 1.
REQ-031 Minimum spacing between wrt pulses SHALL be 1 (XFER) + GAP_CYC + 1 (IDLE) cycles after spi_done.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, owner 0, priority to requester 0, watchdog and gap counters 0, all pulse outputs 0, SS0_n = SS1_n = 1.
REQ-033 Reset mid-XFER SHALL abandon the transaction with no done/err pulse.

Structure
REQ-034 The state enum and requester-index constants (REQ_INERT = 0, REQ_A2D = 1) SHALL live in a shared package spi_arb_pkg.
REQ-035 The block SHALL contain no SPI shift logic; SPI_mnrch SHALL be instantiated alongside it at the next level up, not inside it.

Verification
REQ-036 Single req0 with wt_data0 = 0xA600 -> gnt0 and wrt same cycle, wt_data = 0xA600, SS0_n follows spi_SS_n, SS1_n = 1, done0 one cycle on spi_done with rd_data = model value.
REQ-037 req0 and req1 high together from reset -> req0 served first, then req1 after exactly GAP_CYC+1 cycles past done0.
REQ-038 lock0 high at done0, both requesting -> requester 0 granted again; lock0 low next time -> requester 1 granted.
REQ-039 spi_done never returned (TO_W = 4) -> err pulse 15 cycles after wrt, no done, return to IDLE after GAP.
REQ-040 rst_n low during XFER -> SS0_n = SS1_n = 1 immediately, no done/err, next req0 arbitrated normally after release.
REQ-041 Stray spi_done in IDLE/GAP -> no done pulse, no state change.
